// File: rtl/corePckg.sv
// Shared core types: writeback/ALU result structs, memory FSM states and load/store width codes.
package corePckg;

  localparam logic [2:0] cLsB  = 3'b000;
  localparam logic [2:0] cLsH  = 3'b001;
  localparam logic [2:0] cLsW  = 3'b010;
  localparam logic [2:0] cLsBU = 3'b100;
  localparam logic [2:0] cLsHU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } tMemState;

  typedef struct packed {
    logic        dv;
    logic [4:0]  addr;
    logic [31:0] data;
  } tRegOp;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [2:0]  opType;
    logic [4:0]  rdAddr;
    logic [31:0] addr;
    logic [31:0] data;
  } tMemOp;

  typedef struct packed {
    tMemOp memOp;
    tRegOp regOp;
  } tAluOut;

  function automatic logic isValidOp(input logic [2:0] op);
    return (op == cLsB) || (op == cLsH) || (op == cLsW) || (op == cLsBU) || (op == cLsHU);
  endfunction

  function automatic logic isMisaligned(input logic [2:0] op, input logic [1:0] lo);
    return ((op == cLsH || op == cLsHU) && lo[0]) || ((op == cLsW) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering: store byte-enables/data replication and load extract/extend.
module mem_align
  import corePckg::*;
(
  input  logic [2:0]  i_stOp,
  input  logic [1:0]  i_stAddr,
  input  logic [31:0] i_stData,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ldOp,
  input  logic [1:0]  i_ldAddr,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ldData
);
  logic [31:0] w_shifted;

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_stData;
    case (i_stOp)
      cLsB, cLsBU: begin
        o_be    = 4'b0001 << i_stAddr;
        o_wdata = {4{i_stData[7:0]}};
      end
      cLsH, cLsHU: begin
        o_be    = 4'b0011 << {i_stAddr[1], 1'b0};
        o_wdata = {2{i_stData[15:0]}};
      end
      cLsW:    o_be = 4'b1111;
      default: o_be = 4'b0000;
    endcase
  end

  always_comb begin
    w_shifted = i_rdata;
    o_ldData  = i_rdata;
    case (i_ldOp)
      cLsB, cLsBU: begin
        w_shifted = i_rdata >> {i_ldAddr, 3'b000};
        o_ldData  = i_ldOp[2] ? {24'd0, w_shifted[7:0]} : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      cLsH, cLsHU: begin
        w_shifted = i_rdata >> {i_ldAddr[1], 4'b0000};
        o_ldData  = i_ldOp[2] ? {16'd0, w_shifted[15:0]} : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      default: o_ldData = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Load/store unit: one bus access per memory op, upstream stalled until ack or ack timeout.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses on oMisalign instead of issuing them.
module mem_access
  import corePckg::*;
#(
  parameter int unsigned pAckTimeout = 16
) (
  input  logic        iClk,
  input  logic        iRst,
  input  tAluOut      iAluOut,
  output logic        oStall,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWData,
  output logic [3:0]  oMemBe,
  input  logic        iMemAck,
  input  logic [31:0] iMemRData,
  output tRegOp       oRegOp,
  output logic        oBusErr
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        oMisalign
`endif
);
  tMemState    r_state, w_nextState;
  logic [31:0] r_cnt;
  logic        r_done, r_we, r_isLoad, r_busErr;
  logic [2:0]  r_opType;
  logic [1:0]  r_addrLo;
  logic [4:0]  r_rdAddr;
  logic [31:0] r_memAddr, r_memWData;
  logic [3:0]  r_memBe;
  tRegOp       r_regOp;
  tMemOp       w_memOp;
  logic        w_isMem, w_misal, w_bad, w_accept, w_drop, w_ack, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ldData;

  assign w_memOp = iAluOut.memOp;
  assign w_isMem = w_memOp.read | w_memOp.write;
`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misal = isMisaligned(w_memOp.opType, w_memOp.addr[1:0]);
`else
  assign w_misal = 1'b0;
`endif
  assign w_bad   = !isValidOp(w_memOp.opType) || w_misal;

  mem_align u_align (
    .i_stOp   (w_memOp.opType),
    .i_stAddr (w_memOp.addr[1:0]),
    .i_stData (w_memOp.data),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .i_ldOp   (r_opType),
    .i_ldAddr (r_addrLo),
    .i_rdata  (iMemRData),
    .o_ldData (w_ldData)
  );

  // r_done marks the cycle after completion: the finished op is still held upstream
  // (it was stalled on the final edge) and must not be accepted a second time.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_drop      = 1'b0;
    w_ack       = 1'b0;
    w_timeout   = 1'b0;
    oStall      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_isMem && !r_done && !iRst) begin
          oStall = 1'b1;
          if (w_bad) begin
            w_drop = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_nextState = BUSY;
          end
        end
      end
      BUSY: begin
        oStall = 1'b1;
        if (iMemAck) begin
          w_ack       = 1'b1;
          w_nextState = IDLE;
        end else if (pAckTimeout != 0 && r_cnt == pAckTimeout - 1) begin
          w_timeout   = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state    <= IDLE;
      r_cnt      <= 32'd0;
      r_done     <= 1'b0;
      r_we       <= 1'b0;
      r_isLoad   <= 1'b0;
      r_busErr   <= 1'b0;
      r_opType   <= 3'd0;
      r_addrLo   <= 2'd0;
      r_rdAddr   <= 5'd0;
      r_memAddr  <= 32'd0;
      r_memWData <= 32'd0;
      r_memBe    <= 4'd0;
      r_regOp    <= '0;
    end else begin
      r_state  <= w_nextState;
      r_done   <= w_ack | w_timeout | w_drop;
      r_busErr <= w_timeout;
      r_regOp  <= '0;
      if (w_accept) begin
        r_cnt      <= 32'd0;
        r_we       <= w_memOp.write;
        r_isLoad   <= !w_memOp.write;
        r_opType   <= w_memOp.opType;
        r_addrLo   <= w_memOp.addr[1:0];
        r_rdAddr   <= w_memOp.rdAddr;
        r_memAddr  <= {w_memOp.addr[31:2], 2'b00};
        r_memWData <= w_wdata;
        r_memBe    <= w_be;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (w_ack && r_isLoad) begin
        r_regOp.dv   <= (r_rdAddr != 5'd0);
        r_regOp.addr <= r_rdAddr;
        r_regOp.data <= w_ldData;
      end else if (r_state == IDLE && !w_isMem) begin
        r_regOp <= iAluOut.regOp;
      end
    end
  end

  assign oMemReq   = (r_state == BUSY);
  assign oMemWe    = r_we & (r_state == BUSY);
  assign oMemAddr  = r_memAddr;
  assign oMemWData = r_memWData;
  assign oMemBe    = r_memBe;
  assign oRegOp    = r_regOp;
  assign oBusErr   = r_busErr;

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;
  always_ff @(posedge iClk) begin
    if (iRst) r_misalign <= 1'b0;
    else      r_misalign <= w_drop & w_misal;
  end
  assign oMisalign = r_misalign;
`endif

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter pAckTimeout, default 16, meaning max cycles waiting for iMemAck before abort (0 = wait forever).
REQ-002 SHALL have ports: iClk  in  1  core clock, all logic rising-edge.
REQ-003 iRst  in  1  synchronous reset, active-high.
REQ-004 iAluOut  in  tAluOut  execute result; memOp.read/write request memory access, regOp is the non-memory writeback.
REQ-005 oStall  out  1  upstream SHALL hold iAluOut stable while high.
REQ-006 oMemReq  out  1  bus request; oMemWe  out  1  write strobe; oMemAddr  out  32  word-aligned byte address; oMemWData  out  32; oMemBe  out  4  byte enables.
REQ-007 iMemAck  in  1  one-cycle completion; iMemRData  in  32  read data valid with iMemAck.
REQ-008 oRegOp  out  tRegOp  registered writeback to the register file.
REQ-009 oBusErr  out  1  one-cycle pulse on timeout abort.

Function
REQ-010 SHALL implement FSM states IDLE, BUSY.
REQ-011 IDLE with memOp.read=0 and memOp.write=0: iAluOut.regOp SHALL appear on oRegOp one cycle later (1-cycle latency); oStall=0.
REQ-012 IDLE with read or write set: SHALL latch addr/data/opType/rdAddr, go BUSY, drive oStall=1 combinationally in the acceptance cycle.
REQ-013 If read and write are both set, write SHALL win and no writeback occurs.
REQ-014 BUSY: oMemReq=1 with oMemAddr/oMemWe/oMemWData/oMemBe constant until iMemAck or timeout; oStall=1 throughout, including the ack cycle.
REQ-015 On iMemAck in BUSY: return to IDLE; oMemReq deasserts next cycle; a new request is accepted no earlier than the cycle after the ack.
REQ-016 Load completion SHALL produce oRegOp.dv=1, addr=rdAddr, data=extracted value one cycle after iMemAck; dv SHALL be 0 when rdAddr=0.
REQ-017 opType (funct3): 000 B, 001 H, 010 W, 100 BU, 101 HU; other values SHALL issue no bus access, no writeback.
REQ-018 Stores: SB Be=0001<<addr[1:0], WData={4{data[7:0]}}; SH Be=0011<<{addr[1],0}, WData={2{data[15:0]}}; SW Be=1111.
REQ-019 Loads: value=iMemRData>>(8*addr[1:0]) for B/BU, >>(16*addr[1]) for H/HU; B/H sign-extend, BU/HU zero-extend.
REQ-020 oMemAddr SHALL be {addr[31:2],2'b00}.
REQ-021 Timeout: counter counts BUSY cycles; at count=pAckTimeout without ack SHALL drop oMemReq, pulse oBusErr, return IDLE, no writeback.
REQ-022 iMemAck while IDLE SHALL be ignored.

Reset
REQ-023 iRst SHALL force IDLE, oMemReq=0, oMemWe=0, oMemBe=0, oMemAddr=0, oMemWData=0, oRegOp=0, oStall=0, oBusErr=0, counter=0 on the next edge, aborting any BUSY transaction.

Configuration
REQ-024 With MEM_MISALIGN_TRAP_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 SHALL issue no bus access, pulse output oMisalign (1 bit) one cycle after acceptance, no writeback, oStall only in the acceptance cycle.
REQ-025 Without MEM_MISALIGN_TRAP_EN: oMisalign SHALL not exist; misaligned low address bits SHALL be ignored (H uses addr[1], W ignores addr[1:0]).

Structure
REQ-026 corePckg SHALL gain tMemState enum (IDLE, BUSY) and opType constants cLsB, cLsH, cLsW, cLsBU, cLsHU.
REQ-027 Byte-enable/store-replication and load extract/extend logic SHALL be one combinational sub-module mem_align; FSM, counter and registers stay in mem_access.

Verification
REQ-028 LW addr 0x100, ack after 3 cycles with RData 0xDEADBEEF, rdAddr 5 -> oStall high 4 cycles, oRegOp {dv=1,addr=5,data=0xDEADBEEF} one cycle after ack.
REQ-029 LB addr 0x103, RData 0x80112233 -> data 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
REQ-030 SB addr 0x201 data 0x000000AB -> oMemBe 0010, oMemWData 0xABABABAB, oMemAddr 0x200, oMemWe=1, no writeback.
REQ-031 pAckTimeout=4, no ack -> oMemReq 4 cycles, oBusErr one pulse, oRegOp.dv=0, next request accepted.
REQ-032 iRst asserted during BUSY, then late iMemAck -> all outputs zero, ack ignored, no writeback.
REQ-033 Macro defined, LW addr 0x102 -> oMisalign pulse, oMemReq never high; macro undefined -> oMemAddr 0x100, full word loaded.
